// File: rtl/cnn_load_sequencer.sv
// cnn_load_sequencer: host-side job controller for the CNN core.
// Latches one layer job, pulses cnn_start, streams filter / psum / tagged ifmap
// words into the core buffers through one-entry holding registers, appends the
// zero flush row, raises psum_mode and drains the result buffer to the host.
// Optional feature macro: CNN_SEQ_FLUSH_EN (defined: FLUSH state present;
// undefined: LOAD goes straight to PSUM and no flush row is written).
module cnn_load_sequencer #(
    parameter int DATA_WIDTH        = 16,
    parameter int LEN_WIDTH         = 8,
    parameter int FILTER_SIZE_WIDTH = 5,
    parameter int STRIDE_WIDTH      = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_go,
    input  logic [STRIDE_WIDTH-1:0]      cfg_stride,
    input  logic [FILTER_SIZE_WIDTH-1:0] cfg_filter_size,
    input  logic [LEN_WIDTH-1:0]         cfg_if_len,
    input  logic [LEN_WIDTH-1:0]         cfg_flt_len,
    input  logic [LEN_WIDTH-1:0]         cfg_psum_len,
    input  logic [LEN_WIDTH-1:0]         cfg_res_len,
    output logic                         busy,
    output logic                         done,
    input  logic                         if_src_valid,
    input  logic [DATA_WIDTH-1:0]        if_src_data,
    output logic                         if_src_ready,
    input  logic                         flt_src_valid,
    input  logic [DATA_WIDTH-1:0]        flt_src_data,
    output logic                         flt_src_ready,
    input  logic                         psum_src_valid,
    input  logic [DATA_WIDTH-1:0]        psum_src_data,
    output logic                         psum_src_ready,
    output logic                         cnn_start,
    output logic [STRIDE_WIDTH-1:0]      cnn_stride,
    output logic [FILTER_SIZE_WIDTH-1:0] cnn_filter_size,
    output logic                         cnn_psum_mode,
    output logic [DATA_WIDTH+1:0]        IFmap_buffer_in,
    output logic                         IFmap_buffer_write_enable,
    input  logic                         IFmap_buffer_ready,
    output logic [DATA_WIDTH-1:0]        filter_buffer_in,
    output logic                         filter_buffer_write_enable,
    input  logic                         filter_buffer_ready,
    output logic [DATA_WIDTH-1:0]        psum_buffer_in,
    output logic                         psum_buffer_wen,
    input  logic                         psum_buffer_ready,
    output logic                         result_buffer_read_enable,
    input  logic                         result_buffer_valid,
    input  logic [DATA_WIDTH-1:0]        result_buffer_out,
    output logic                         res_valid,
    output logic [DATA_WIDTH-1:0]        res_data,
    input  logic                         res_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_LOAD  = 3'd2,
        S_FLUSH = 3'd3,
        S_PSUM  = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic [STRIDE_WIDTH-1:0]      stride_q, stride_d;
    logic [FILTER_SIZE_WIDTH-1:0] fs_q, fs_d;
    logic [LEN_WIDTH-1:0]         if_len_q, if_len_d, flt_len_q, flt_len_d;
    logic [LEN_WIDTH-1:0]         psum_len_q, psum_len_d, res_len_q, res_len_d;
    logic [LEN_WIDTH-1:0]         if_cnt_q, if_cnt_d, flt_cnt_q, flt_cnt_d;
    logic [LEN_WIDTH-1:0]         psum_cnt_q, psum_cnt_d, res_cnt_q, res_cnt_d;
    logic                         if_hold_q, if_hold_d, flt_hold_q, flt_hold_d;
    logic                         psum_hold_q, psum_hold_d;
    logic [DATA_WIDTH+1:0]        if_data_q, if_data_d;
    logic [DATA_WIDTH-1:0]        flt_data_q, flt_data_d, psum_data_q, psum_data_d;
    logic                         if_rdy_q, if_rdy_d, flt_rdy_q, flt_rdy_d;
    logic                         psum_rdy_q, psum_rdy_d;
    logic                         start_q, start_d, done_q, done_d, busy_q, busy_d;
    logic                         psum_mode_q, psum_mode_d, rd_en_q, rd_en_d;
    logic                         res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0]        res_data_q, res_data_d;

`ifdef CNN_SEQ_FLUSH_EN
    logic [LEN_WIDTH-1:0]         fs_ext;
    assign fs_ext = LEN_WIDTH'(fs_q);
`endif

    // Word tag: bit1 marks the first word of a row, bit0 the last one.
    function automatic logic [1:0] tag_f(input logic [LEN_WIDTH-1:0] idx,
                                         input logic [LEN_WIDTH-1:0] len);
        tag_f = {(idx == {LEN_WIDTH{1'b0}}), (idx == (len - LEN_WIDTH'(1)))};
    endfunction

    // Next-state, channel, drain and registered-output computation.
    always_comb begin
        state_d     = state_q;
        stride_d    = stride_q;
        fs_d        = fs_q;
        if_len_d    = if_len_q;
        flt_len_d   = flt_len_q;
        psum_len_d  = psum_len_q;
        res_len_d   = res_len_q;
        if_cnt_d    = if_cnt_q;
        flt_cnt_d   = flt_cnt_q;
        psum_cnt_d  = psum_cnt_q;
        res_cnt_d   = res_cnt_q;
        if_hold_d   = if_hold_q;
        flt_hold_d  = flt_hold_q;
        psum_hold_d = psum_hold_q;
        if_data_d   = if_data_q;
        flt_data_d  = flt_data_q;
        psum_data_d = psum_data_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        psum_mode_d = psum_mode_q;

        // ifmap channel: a write accepted by the core empties the holder;
        // a refill can only happen on a later edge.
        if (if_hold_q && IFmap_buffer_ready) begin
            if_hold_d = 1'b0;
            if_cnt_d  = if_cnt_q + LEN_WIDTH'(1);
        end else if (if_rdy_q && if_src_valid) begin
            if_hold_d = 1'b1;
            if_data_d = {tag_f(if_cnt_q, if_len_q), if_src_data};
`ifdef CNN_SEQ_FLUSH_EN
        end else if ((state_q == S_FLUSH) && !if_hold_q && (if_cnt_q < fs_ext)) begin
            if_hold_d = 1'b1;
            if_data_d = {tag_f(if_cnt_q, fs_ext), {DATA_WIDTH{1'b0}}};
`endif
        end else begin
            if_hold_d = if_hold_q;
        end

        // filter channel
        if (flt_hold_q && filter_buffer_ready) begin
            flt_hold_d = 1'b0;
            flt_cnt_d  = flt_cnt_q + LEN_WIDTH'(1);
        end else if (flt_rdy_q && flt_src_valid) begin
            flt_hold_d = 1'b1;
            flt_data_d = flt_src_data;
        end else begin
            flt_hold_d = flt_hold_q;
        end

        // psum channel
        if (psum_hold_q && psum_buffer_ready) begin
            psum_hold_d = 1'b0;
            psum_cnt_d  = psum_cnt_q + LEN_WIDTH'(1);
        end else if (psum_rdy_q && psum_src_valid) begin
            psum_hold_d = 1'b1;
            psum_data_d = psum_src_data;
        end else begin
            psum_hold_d = psum_hold_q;
        end

        // result path: the output register is either handed to the host or refilled
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            res_cnt_d   = res_cnt_q + LEN_WIDTH'(1);
        end else if (rd_en_q && result_buffer_valid) begin
            res_valid_d = 1'b1;
            res_data_d  = result_buffer_out;
        end else begin
            res_valid_d = res_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_go) begin
                    state_d    = S_START;
                    stride_d   = cfg_stride;
                    fs_d       = cfg_filter_size;
                    if_len_d   = cfg_if_len;
                    flt_len_d  = cfg_flt_len;
                    psum_len_d = cfg_psum_len;
                    res_len_d  = cfg_res_len;
                    if_cnt_d   = {LEN_WIDTH{1'b0}};
                    flt_cnt_d  = {LEN_WIDTH{1'b0}};
                    psum_cnt_d = {LEN_WIDTH{1'b0}};
                    res_cnt_d  = {LEN_WIDTH{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: state_d = S_LOAD;
            S_LOAD: begin
                // a channel is finished once its count of accepted writes hits len
                if ((if_cnt_q == if_len_q) && (flt_cnt_q == flt_len_q) &&
                    (psum_cnt_q == psum_len_q)) begin
`ifdef CNN_SEQ_FLUSH_EN
                    if (fs_q != {FILTER_SIZE_WIDTH{1'b0}}) begin
                        state_d  = S_FLUSH;
                        if_cnt_d = {LEN_WIDTH{1'b0}};
                    end else begin
                        state_d = S_PSUM;
                    end
`else
                    state_d = S_PSUM;
`endif
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef CNN_SEQ_FLUSH_EN
            S_FLUSH: begin
                if ((if_cnt_q == fs_ext) && !if_hold_q) begin
                    state_d = S_PSUM;
                end else begin
                    state_d = S_FLUSH;
                end
            end
`endif
            S_PSUM: state_d = S_DRAIN;
            S_DRAIN: begin
                if ((res_cnt_q == res_len_q) && !res_valid_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // outputs are registered: derive them from the next-state values
        start_d    = (state_d == S_START);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
        if_rdy_d   = (state_d == S_LOAD) && (if_cnt_d < if_len_q) && !if_hold_d;
        flt_rdy_d  = (state_d == S_LOAD) && (flt_cnt_d < flt_len_q) && !flt_hold_d;
        psum_rdy_d = (state_d == S_LOAD) && (psum_cnt_d < psum_len_q) && !psum_hold_d;
        rd_en_d    = (state_d == S_DRAIN) && !res_valid_d && (res_cnt_d < res_len_q);
        if (state_d == S_PSUM) begin
            psum_mode_d = 1'b1;
        end else if (state_d == S_START) begin
            psum_mode_d = 1'b0;
        end else begin
            psum_mode_d = psum_mode_q;
        end
    end

    // State, counter, holder and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            stride_q    <= {STRIDE_WIDTH{1'b0}};
            fs_q        <= {FILTER_SIZE_WIDTH{1'b0}};
            if_len_q    <= {LEN_WIDTH{1'b0}};
            flt_len_q   <= {LEN_WIDTH{1'b0}};
            psum_len_q  <= {LEN_WIDTH{1'b0}};
            res_len_q   <= {LEN_WIDTH{1'b0}};
            if_cnt_q    <= {LEN_WIDTH{1'b0}};
            flt_cnt_q   <= {LEN_WIDTH{1'b0}};
            psum_cnt_q  <= {LEN_WIDTH{1'b0}};
            res_cnt_q   <= {LEN_WIDTH{1'b0}};
            if_hold_q   <= 1'b0;
            flt_hold_q  <= 1'b0;
            psum_hold_q <= 1'b0;
            if_data_q   <= {(DATA_WIDTH+2){1'b0}};
            flt_data_q  <= {DATA_WIDTH{1'b0}};
            psum_data_q <= {DATA_WIDTH{1'b0}};
            if_rdy_q    <= 1'b0;
            flt_rdy_q   <= 1'b0;
            psum_rdy_q  <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            psum_mode_q <= 1'b0;
            rd_en_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            stride_q    <= stride_d;
            fs_q        <= fs_d;
            if_len_q    <= if_len_d;
            flt_len_q   <= flt_len_d;
            psum_len_q  <= psum_len_d;
            res_len_q   <= res_len_d;
            if_cnt_q    <= if_cnt_d;
            flt_cnt_q   <= flt_cnt_d;
            psum_cnt_q  <= psum_cnt_d;
            res_cnt_q   <= res_cnt_d;
            if_hold_q   <= if_hold_d;
            flt_hold_q  <= flt_hold_d;
            psum_hold_q <= psum_hold_d;
            if_data_q   <= if_data_d;
            flt_data_q  <= flt_data_d;
            psum_data_q <= psum_data_d;
            if_rdy_q    <= if_rdy_d;
            flt_rdy_q   <= flt_rdy_d;
            psum_rdy_q  <= psum_rdy_d;
            start_q     <= start_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            psum_mode_q <= psum_mode_d;
            rd_en_q     <= rd_en_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign busy                       = busy_q;
    assign done                       = done_q;
    assign if_src_ready               = if_rdy_q;
    assign flt_src_ready              = flt_rdy_q;
    assign psum_src_ready             = psum_rdy_q;
    assign cnn_start                  = start_q;
    assign cnn_stride                 = stride_q;
    assign cnn_filter_size            = fs_q;
    assign cnn_psum_mode              = psum_mode_q;
    assign IFmap_buffer_in            = if_data_q;
    assign IFmap_buffer_write_enable  = if_hold_q;
    assign filter_buffer_in           = flt_data_q;
    assign filter_buffer_write_enable = flt_hold_q;
    assign psum_buffer_in             = psum_data_q;
    assign psum_buffer_wen            = psum_hold_q;
    assign result_buffer_read_enable  = rd_en_q;
    assign res_valid                  = res_valid_q;
    assign res_data                   = res_data_q;

endmodule

// File: tb/tb_cnn_load_sequencer.sv
// Directed testbench for cnn_load_sequencer. Background process models the
// host sources, the result buffer and the host result sink and logs every
// accepted buffer write; the scenario tasks check the logs against hand-built
// expectations. Flush expectations follow the CNN_SEQ_FLUSH_EN macro.
module tb_cnn_load_sequencer;

`ifdef CNN_SEQ_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    logic        clk, reset, cfg_go;
    logic [4:0]  cfg_stride, cfg_filter_size;
    logic [7:0]  cfg_if_len, cfg_flt_len, cfg_psum_len, cfg_res_len;
    logic        busy, done;
    logic        if_src_valid, flt_src_valid, psum_src_valid;
    logic [15:0] if_src_data, flt_src_data, psum_src_data;
    logic        if_src_ready, flt_src_ready, psum_src_ready;
    logic        cnn_start, cnn_psum_mode;
    logic [4:0]  cnn_stride, cnn_filter_size;
    logic [17:0] IFmap_buffer_in;
    logic        IFmap_buffer_write_enable, IFmap_buffer_ready;
    logic [15:0] filter_buffer_in, psum_buffer_in, result_buffer_out, res_data;
    logic        filter_buffer_write_enable, filter_buffer_ready;
    logic        psum_buffer_wen, psum_buffer_ready;
    logic        result_buffer_read_enable, result_buffer_valid;
    logic        res_valid, res_ready;

    cnn_load_sequencer dut (
        .clk(clk), .reset(reset), .cfg_go(cfg_go),
        .cfg_stride(cfg_stride), .cfg_filter_size(cfg_filter_size),
        .cfg_if_len(cfg_if_len), .cfg_flt_len(cfg_flt_len),
        .cfg_psum_len(cfg_psum_len), .cfg_res_len(cfg_res_len),
        .busy(busy), .done(done),
        .if_src_valid(if_src_valid), .if_src_data(if_src_data), .if_src_ready(if_src_ready),
        .flt_src_valid(flt_src_valid), .flt_src_data(flt_src_data), .flt_src_ready(flt_src_ready),
        .psum_src_valid(psum_src_valid), .psum_src_data(psum_src_data),
        .psum_src_ready(psum_src_ready),
        .cnn_start(cnn_start), .cnn_stride(cnn_stride), .cnn_filter_size(cnn_filter_size),
        .cnn_psum_mode(cnn_psum_mode),
        .IFmap_buffer_in(IFmap_buffer_in), .IFmap_buffer_write_enable(IFmap_buffer_write_enable),
        .IFmap_buffer_ready(IFmap_buffer_ready),
        .filter_buffer_in(filter_buffer_in), .filter_buffer_write_enable(filter_buffer_write_enable),
        .filter_buffer_ready(filter_buffer_ready),
        .psum_buffer_in(psum_buffer_in), .psum_buffer_wen(psum_buffer_wen),
        .psum_buffer_ready(psum_buffer_ready),
        .result_buffer_read_enable(result_buffer_read_enable),
        .result_buffer_valid(result_buffer_valid), .result_buffer_out(result_buffer_out),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    logic [87:0] all_outs;
    assign all_outs = {busy, done, if_src_ready, flt_src_ready, psum_src_ready, cnn_start,
                       cnn_stride, cnn_filter_size, cnn_psum_mode, IFmap_buffer_in,
                       IFmap_buffer_write_enable, filter_buffer_in, filter_buffer_write_enable,
                       psum_buffer_in, psum_buffer_wen, result_buffer_read_enable,
                       res_valid, res_data};

    int total = 0;
    int bad   = 0;

    // owned by the main sequence
    int if_n = 0, flt_n = 0, psum_n = 0, gen = 0;
    bit toggle_en = 1'b0;
    // owned by the background process
    int rd_idx = 0, rd_viol = 0, start_cnt = 0;
    logic [17:0] if_q[$];
    logic [15:0] flt_q[$], psum_q[$], res_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background: host sources, result buffer, result sink and write logging.
    initial begin
        int if_sent, flt_sent, psum_sent, gen_seen;
        bit f_if, f_flt, f_psum, f_rd;
        if_sent = 0; flt_sent = 0; psum_sent = 0; gen_seen = 0;
        if_src_valid = 1'b0; flt_src_valid = 1'b0; psum_src_valid = 1'b0;
        if_src_data = 16'h1000; flt_src_data = 16'h2000; psum_src_data = 16'h3000;
        result_buffer_out = 16'h4000; res_ready = 1'b0;
        forever begin
            @(negedge clk);
            f_if   = if_src_valid && if_src_ready;
            f_flt  = flt_src_valid && flt_src_ready;
            f_psum = psum_src_valid && psum_src_ready;
            f_rd   = result_buffer_read_enable && result_buffer_valid;
            if (IFmap_buffer_write_enable && IFmap_buffer_ready) if_q.push_back(IFmap_buffer_in);
            if (filter_buffer_write_enable && filter_buffer_ready) flt_q.push_back(filter_buffer_in);
            if (psum_buffer_wen && psum_buffer_ready) psum_q.push_back(psum_buffer_in);
            if (res_valid && res_ready) res_q.push_back(res_data);
            if (result_buffer_read_enable && res_valid) rd_viol++;
            if (cnn_start) start_cnt++;
            @(posedge clk);
            #1;
            if (f_if) begin if_sent++; if_src_data = 16'(32'h1000 + if_sent); end
            if (f_flt) begin flt_sent++; flt_src_data = 16'(32'h2000 + flt_sent); end
            if (f_psum) begin psum_sent++; psum_src_data = 16'(32'h3000 + psum_sent); end
            if (f_rd) begin rd_idx++; result_buffer_out = 16'(32'h4000 + rd_idx); end
            res_ready = toggle_en ? ~res_ready : 1'b1;
            if (gen != gen_seen) begin
                gen_seen = gen;
                if_sent = 0; flt_sent = 0; psum_sent = 0;
                if_src_data = 16'h1000; flt_src_data = 16'h2000; psum_src_data = 16'h3000;
            end
            if_src_valid   = (if_sent < if_n);
            flt_src_valid  = (flt_sent < flt_n);
            psum_src_valid = (psum_sent < psum_n);
        end
    end

    // Expected ifmap buffer word i of a job: data words, then the flush row.
    function automatic logic [17:0] exp_if(input int i, input int il, input int fs);
        logic [1:0] t;
        if (i < il) begin
            t = {(i == 0), (i == il - 1)};
            return {t, 16'(32'h1000 + i)};
        end else begin
            t = {(i - il == 0), (i - il == fs - 1)};
            return {t, 16'h0000};
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic setup_job(input int i_n, input int f_n, input int p_n, input bit tog);
        if_n = i_n; flt_n = f_n; psum_n = p_n; toggle_en = tog;
        gen++;
        step();
        step();
    endtask

    task automatic go(input int st, input int fs, input int il, input int fl,
                      input int pl, input int rl);
        cfg_stride = 5'(st); cfg_filter_size = 5'(fs);
        cfg_if_len = 8'(il); cfg_flt_len = 8'(fl); cfg_psum_len = 8'(pl); cfg_res_len = 8'(rl);
        cfg_go = 1'b1;
        step();
        cfg_go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_go = 1'b0; cfg_stride = 5'd0; cfg_filter_size = 5'd0;
        cfg_if_len = 8'd0; cfg_flt_len = 8'd0; cfg_psum_len = 8'd0; cfg_res_len = 8'd0;
        IFmap_buffer_ready = 1'b0; filter_buffer_ready = 1'b0; psum_buffer_ready = 1'b0;
        result_buffer_valid = 1'b0;
        repeat (3) step();
        total++;
        if (all_outs !== 88'd0) begin bad++; $display("FAIL reset_outs: got %h want 0", all_outs); end
        reset = 1'b0;
        step();
        total++;
        if ({busy, if_src_ready, result_buffer_read_enable} !== 3'b000) begin
            bad++; $display("FAIL idle_after_reset: got %b want 000",
                            {busy, if_src_ready, result_buffer_read_enable});
        end
    endtask

    task automatic test_basic();
        int ib, fb, pb, rb, rbase, n_if;
        bit ok;
        setup_job(12, 5, 8, 1'b0);
        IFmap_buffer_ready = 1'b1; filter_buffer_ready = 1'b1; psum_buffer_ready = 1'b1;
        result_buffer_valid = 1'b1;
        ib = if_q.size(); fb = flt_q.size(); pb = psum_q.size(); rb = res_q.size(); rbase = rd_idx;
        go(1, 5, 12, 5, 8, 4);
        total++;
        if ({cnn_start, cnn_stride, cnn_filter_size, busy} !== {1'b1, 5'd1, 5'd5, 1'b1}) begin
            bad++; $display("FAIL basic_start: got %b want %b",
                {cnn_start, cnn_stride, cnn_filter_size, busy}, {1'b1, 5'd1, 5'd5, 1'b1});
        end
        wait_done(400, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL basic_done: got timeout want done"); end
        @(negedge clk);
        total++;
        if ({done, busy, cnn_psum_mode} !== 3'b001) begin
            bad++; $display("FAIL basic_done_pulse: got %b want 001", {done, busy, cnn_psum_mode});
        end
        n_if = 12 + (FLUSH_ON ? 5 : 0);
        total++;
        if (if_q.size() - ib !== n_if) begin
            bad++; $display("FAIL basic_if_count: got %0d want %0d", if_q.size() - ib, n_if);
        end else begin
            for (int i = 0; i < n_if; i++) begin
                total++;
                if (if_q[ib + i] !== exp_if(i, 12, 5)) begin
                    bad++; $display("FAIL basic_if_word%0d: got %h want %h", i, if_q[ib + i],
                                    exp_if(i, 12, 5));
                end
            end
        end
        total++;
        if ((flt_q.size() - fb !== 5) || (psum_q.size() - pb !== 8) || (res_q.size() - rb !== 4)) begin
            bad++; $display("FAIL basic_counts: got flt=%0d psum=%0d res=%0d want 5 8 4",
                            flt_q.size() - fb, psum_q.size() - pb, res_q.size() - rb);
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (psum_q[pb + i] !== 16'(32'h3000 + i)) begin
                    bad++; $display("FAIL basic_psum%0d: got %h want %h", i, psum_q[pb + i],
                                    16'(32'h3000 + i));
                end
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (res_q[rb + i] !== 16'(32'h4000 + rbase + i)) begin
                    bad++; $display("FAIL basic_res%0d: got %h want %h", i, res_q[rb + i],
                                    16'(32'h4000 + rbase + i));
                end
            end
        end
    endtask

    task automatic test_filter_stall();
        int fb, pb, stable_bad;
        logic [15:0] d0;
        bit ok;
        setup_job(12, 5, 8, 1'b0);
        filter_buffer_ready = 1'b0;
        fb = flt_q.size(); pb = psum_q.size();
        go(1, 5, 12, 5, 8, 2);
        repeat (3) @(negedge clk);
        d0 = filter_buffer_in;
        stable_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!filter_buffer_write_enable || (filter_buffer_in !== d0)) stable_bad++;
        end
        total++;
        if ((d0 !== 16'h2000) || (stable_bad != 0)) begin
            bad++; $display("FAIL stall_hold: got data=%h unstable=%0d want 2000 0", d0, stable_bad);
        end
        total++;
        if ((psum_q.size() - pb !== 8) || (flt_q.size() - fb !== 0)) begin
            bad++; $display("FAIL stall_psum_free: got psum=%0d flt=%0d want 8 0",
                            psum_q.size() - pb, flt_q.size() - fb);
        end
        step();
        filter_buffer_ready = 1'b1;
        wait_done(400, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL stall_done: got timeout want done"); end
        total++;
        if (flt_q.size() - fb !== 5) begin
            bad++; $display("FAIL stall_flt_count: got %0d want 5", flt_q.size() - fb);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (flt_q[fb + i] !== 16'(32'h2000 + i)) begin
                    bad++; $display("FAIL stall_flt%0d: got %h want %h", i, flt_q[fb + i],
                                    16'(32'h2000 + i));
                end
            end
        end
    endtask

    task automatic test_single_word();
        int ib, n_if;
        bit ok;
        setup_job(1, 0, 0, 1'b0);
        ib = if_q.size();
        total++;
        if (cnn_psum_mode !== 1'b1) begin
            bad++; $display("FAIL psum_mode_held: got %b want 1", cnn_psum_mode);
        end
        go(2, 1, 1, 0, 0, 1);
        total++;
        if ({cnn_start, cnn_psum_mode} !== 2'b10) begin
            bad++; $display("FAIL single_start: got %b want 10", {cnn_start, cnn_psum_mode});
        end
        wait_done(200, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL single_done: got timeout want done"); end
        n_if = 1 + (FLUSH_ON ? 1 : 0);
        total++;
        if (if_q.size() - ib !== n_if) begin
            bad++; $display("FAIL single_count: got %0d want %0d", if_q.size() - ib, n_if);
        end else begin
            total++;
            if (if_q[ib] !== 18'h31000) begin
                bad++; $display("FAIL single_word: got %h want 31000", if_q[ib]);
            end
            if (FLUSH_ON) begin
                total++;
                if (if_q[ib + 1] !== 18'h30000) begin
                    bad++; $display("FAIL single_flush: got %h want 30000", if_q[ib + 1]);
                end
            end
        end
    endtask

    task automatic test_drain_backpressure();
        int rb, rbase, v0;
        bit ok;
        setup_job(2, 1, 1, 1'b1);
        rb = res_q.size(); rbase = rd_idx; v0 = rd_viol;
        go(1, 2, 2, 1, 1, 16);
        wait_done(600, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL drain_done: got timeout want done"); end
        total++;
        if (rd_viol != v0) begin
            bad++; $display("FAIL drain_rd_while_full: got %0d want 0", rd_viol - v0);
        end
        total++;
        if (res_q.size() - rb !== 16) begin
            bad++; $display("FAIL drain_count: got %0d want 16", res_q.size() - rb);
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (res_q[rb + i] !== 16'(32'h4000 + rbase + i)) begin
                    bad++; $display("FAIL drain_res%0d: got %h want %h", i, res_q[rb + i],
                                    16'(32'h4000 + rbase + i));
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int ib, n_if;
        bit ok;
        setup_job(12, 0, 0, 1'b0);
        ib = if_q.size();
        go(1, 5, 12, 0, 0, 1);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (if_q.size() - ib >= 3) ok = 1'b1;
        end
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL midrst_progress: got timeout want 3 writes"); end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (all_outs !== 88'd0) begin bad++; $display("FAIL midrst_outs: got %h want 0", all_outs); end
        step();
        reset = 1'b0;
        setup_job(3, 0, 0, 1'b0);
        ib = if_q.size();
        go(1, 2, 3, 0, 0, 1);
        wait_done(200, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL midrst_done: got timeout want done"); end
        n_if = 3 + (FLUSH_ON ? 2 : 0);
        total++;
        if (if_q.size() - ib !== n_if) begin
            bad++; $display("FAIL midrst_count: got %0d want %0d", if_q.size() - ib, n_if);
        end else begin
            for (int i = 0; i < n_if; i++) begin
                total++;
                if (if_q[ib + i] !== exp_if(i, 3, 2)) begin
                    bad++; $display("FAIL midrst_word%0d: got %h want %h", i, if_q[ib + i],
                                    exp_if(i, 3, 2));
                end
            end
        end
    endtask

    task automatic test_go_during_drain();
        int rb, sc;
        bit ok;
        setup_job(2, 1, 1, 1'b1);
        rb = res_q.size();
        go(3, 2, 2, 1, 1, 6);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (res_q.size() - rb >= 1) ok = 1'b1;
        end
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL go_drain_reach: got timeout want drain"); end
        step();
        sc = start_cnt;
        go(7, 9, 4, 4, 4, 1);
        total++;
        if ({busy, cnn_start, cnn_stride, cnn_filter_size} !== {1'b1, 1'b0, 5'd3, 5'd2}) begin
            bad++; $display("FAIL go_drain_ignored: got %b want %b",
                {busy, cnn_start, cnn_stride, cnn_filter_size}, {1'b1, 1'b0, 5'd3, 5'd2});
        end
        wait_done(400, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL go_drain_done: got timeout want done"); end
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++; $display("FAIL go_drain_busy_fall: got %b want 00", {done, busy});
        end
        repeat (3) step();
        total++;
        if ((res_q.size() - rb !== 6) || (start_cnt != sc) || (busy !== 1'b0)) begin
            bad++; $display("FAIL go_drain_after: got res=%0d starts=%0d busy=%b want 6 0 0",
                            res_q.size() - rb, start_cnt - sc, busy);
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_basic();
        test_filter_stall();
        test_single_word();
        test_drain_backpressure();
        test_reset_mid_load();
        test_go_during_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
